// File: rtl/sim_check_monitor_pkg.sv
// ============================================================================
// sim_check_monitor_pkg : shared offsets, state encoding and helpers
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package sim_check_monitor_pkg;

   localparam int          C_REC_W      = 128;
   localparam logic [1:0]  C_ORDER_WORD = 2'h2;

   localparam logic [4:0]  C_OFF_FLAG   = 5'h00;
   localparam logic [4:0]  C_OFF_FINISH = 5'h04;
   localparam logic [4:0]  C_OFF_LOG    = 5'h08;
   localparam logic [4:0]  C_OFF_TYPE   = 5'h0C;
   localparam logic [4:0]  C_OFF_INDEX  = 5'h10;
   localparam logic [4:0]  C_OFF_RESULT = 5'h14;
   localparam logic [4:0]  C_OFF_EXPECT = 5'h18;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_DONE = 2'd1,
      ST_TMO  = 2'd2
   } state_t;

   function automatic logic [31:0] byte_swap(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sim_check_fifo.sv
// ============================================================================
// sim_check_fifo : error-record queue with combinational head
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_check_fifo #(
   parameter int P_WIDTH = 128,
   parameter int P_DEPTH = 8
)(
   input  logic               iCLOCK,
   input  logic               inRESET,
   input  logic               push,
   input  logic [P_WIDTH-1:0] data,
   input  logic               pop,
   output logic [P_WIDTH-1:0] head,
   output logic               empty,
   output logic               full
);

   localparam int           C_AW      = $clog2(P_DEPTH);
   localparam logic [C_AW:0] C_PTR_ONE = 1;

   logic [P_WIDTH-1:0] r_mem [P_DEPTH];
   logic [C_AW:0]      r_wr_ptr;
   logic [C_AW:0]      r_rd_ptr;
   logic               w_pop_ok;
   logic               w_push_ok;

   // Extra pointer MSB separates full from empty when the index bits match.
   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                      (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
   assign w_pop_ok  = pop & ~empty;
   assign w_push_ok = push & (~full | w_pop_ok);
   assign head      = r_mem[r_rd_ptr[C_AW-1:0]];

   always_ff @(posedge iCLOCK) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr[C_AW-1:0]] <= data;
      end
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/sim_check_monitor.sv
// ============================================================================
// sim_check_monitor : bus snooper turning mailbox writes into check verdicts
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_check_monitor
   import sim_check_monitor_pkg::*;
#(
   parameter logic [31:0] P_BASE_ADDR  = 32'h0002_0000,
   parameter bit          P_BYTE_SWAP  = 1'b1,
   parameter int          P_FIFO_DEPTH = 8,
   parameter logic [31:0] P_TIMEOUT    = 32'd750000
)(
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iMEMORY_REQ,
   input  logic        iMEMORY_LOCK,
   input  logic [1:0]  iMEMORY_ORDER,
   input  logic        iMEMORY_RW,
   input  logic [31:0] iMEMORY_ADDR,
   input  logic [31:0] iMEMORY_DATA,
   input  logic        iERR_RD,
   output logic        oERR_EMPTY,
   output logic [31:0] oERR_TYPE,
   output logic [31:0] oERR_INDEX,
   output logic [31:0] oERR_RESULT,
   output logic [31:0] oERR_EXPECT,
   output logic        oERR_OVERFLOW,
   output logic        oLOG_VALID,
   output logic [31:0] oLOG_DATA,
   output logic [31:0] oCHECK_COUNT,
   output logic [31:0] oFAIL_COUNT,
   output logic        oFINISH,
   output logic        oPASS,
   output logic        oTIMEOUT
);

   localparam logic [31:0] C_TMO_LAST = P_TIMEOUT - 32'd1;
   localparam logic [26:0] C_WINDOW   = P_BASE_ADDR[31:5];

   state_t             r_state;
   state_t             w_state_next;
   logic [31:0]        r_cycle_count;
   logic [31:0]        r_check_count;
   logic [31:0]        r_fail_count;
   logic [31:0]        r_type;
   logic [31:0]        r_index;
   logic [31:0]        r_result;
   logic [31:0]        r_expect;
   logic [31:0]        r_log_data;
   logic               r_log_valid;
   logic               r_overflow;

   logic [31:0]        w_data;
   logic [4:0]         w_offset;
   logic               w_accept;
   logic               w_flag_wr;
   logic               w_flag_fail;
   logic               w_finish_wr;
   logic               w_log_wr;
   logic               w_tmo_hit;
   logic               w_pop_ok;
   logic               w_drop;
   logic [C_REC_W-1:0] w_head;
   logic               w_empty;
   logic               w_full;

   generate
      if (P_BYTE_SWAP) begin : g_swap
         assign w_data = byte_swap(iMEMORY_DATA);
      end else begin : g_raw
         assign w_data = iMEMORY_DATA;
      end
   endgenerate

   assign w_offset    = iMEMORY_ADDR[4:0];
   assign w_accept    = iMEMORY_REQ & ~iMEMORY_LOCK & iMEMORY_RW &
                        (iMEMORY_ORDER == C_ORDER_WORD) &
                        (iMEMORY_ADDR[31:5] == C_WINDOW) &
                        (iMEMORY_ADDR[1:0] == 2'b00) &
                        (r_state == ST_RUN);
   assign w_flag_wr   = w_accept & (w_offset == C_OFF_FLAG);
   assign w_flag_fail = w_flag_wr & ~w_data[0];
   assign w_finish_wr = w_accept & (w_offset == C_OFF_FINISH);
   assign w_log_wr    = w_accept & (w_offset == C_OFF_LOG);
   assign w_tmo_hit   = (P_TIMEOUT != 32'd0) && (r_cycle_count == C_TMO_LAST);

   // A pop frees a slot on the same edge, so only an unaccompanied push drops.
   assign w_pop_ok    = iERR_RD & ~w_empty;
   assign w_drop      = w_flag_fail & w_full & ~w_pop_ok;

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_finish_wr) begin
               w_state_next = ST_DONE;
            end else if (w_tmo_hit) begin
               w_state_next = ST_TMO;
            end
         end
         ST_DONE: w_state_next = ST_DONE;
         ST_TMO:  w_state_next = ST_TMO;
         default: w_state_next = ST_RUN;
      endcase
   end

   always_comb begin
      oFINISH  = 1'b0;
      oTIMEOUT = 1'b0;
      oPASS    = 1'b0;
      case (r_state)
         ST_DONE: begin
            oFINISH = 1'b1;
            oPASS   = (r_fail_count == 32'd0) && (r_check_count != 32'd0);
         end
         ST_TMO: begin
            oFINISH  = 1'b1;
            oTIMEOUT = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_cycle_count <= '0;
         r_check_count <= '0;
         r_fail_count  <= '0;
         r_overflow    <= 1'b0;
      end else begin
         if (r_state == ST_RUN) begin
            r_cycle_count <= sat_inc(r_cycle_count);
         end
         if (w_flag_wr) begin
            r_check_count <= sat_inc(r_check_count);
         end
         if (w_flag_fail) begin
            r_fail_count <= sat_inc(r_fail_count);
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_type      <= '0;
         r_index     <= '0;
         r_result    <= '0;
         r_expect    <= '0;
         r_log_data  <= '0;
         r_log_valid <= 1'b0;
      end else begin
         r_log_valid <= w_log_wr;
         if (w_log_wr) begin
            r_log_data <= w_data;
         end
         if (w_accept) begin
            case (w_offset)
               C_OFF_TYPE:   r_type   <= w_data;
               C_OFF_INDEX:  r_index  <= w_data;
               C_OFF_RESULT: r_result <= w_data;
               C_OFF_EXPECT: r_expect <= w_data;
               default: ;
            endcase
         end
      end
   end

   sim_check_fifo #(
      .P_WIDTH (C_REC_W),
      .P_DEPTH (P_FIFO_DEPTH)
   ) u_fifo (
      .iCLOCK  (iCLOCK),
      .inRESET (inRESET),
      .push    (w_flag_fail),
      .data    ({r_type, r_index, r_result, r_expect}),
      .pop     (iERR_RD),
      .head    (w_head),
      .empty   (w_empty),
      .full    (w_full)
   );

   // Stale storage is masked so an empty queue always presents zeros.
   assign oERR_EMPTY    = w_empty;
   assign oERR_TYPE     = w_empty ? 32'd0 : w_head[127:96];
   assign oERR_INDEX    = w_empty ? 32'd0 : w_head[95:64];
   assign oERR_RESULT   = w_empty ? 32'd0 : w_head[63:32];
   assign oERR_EXPECT   = w_empty ? 32'd0 : w_head[31:0];
   assign oERR_OVERFLOW = r_overflow;
   assign oLOG_VALID    = r_log_valid;
   assign oLOG_DATA     = r_log_data;
   assign oCHECK_COUNT  = r_check_count;
   assign oFAIL_COUNT   = r_fail_count;

endmodule

`default_nettype wire

// File: tb/tb_sim_check_monitor.sv
// ============================================================================
// tb_sim_check_monitor : randomized bench with behavioural reference model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sim_check_monitor;

   localparam logic [31:0] BASE  = 32'h0002_0000;
   localparam int          DEPTH = 2;
   localparam int          TMO   = 100;

   logic        clk, rst_n;
   logic        req, lock, rw, rd;
   logic [1:0]  order;
   logic [31:0] addr, data;
   logic        err_empty, err_ovf, log_valid, finish, pass, timeout;
   logic [31:0] err_type, err_index, err_result, err_expect;
   logic [31:0] log_data, check_count, fail_count;

   sim_check_monitor #(
      .P_BASE_ADDR  (BASE),
      .P_BYTE_SWAP  (1'b1),
      .P_FIFO_DEPTH (DEPTH),
      .P_TIMEOUT    (TMO)
   ) dut (
      .iCLOCK        (clk),
      .inRESET       (rst_n),
      .iMEMORY_REQ   (req),
      .iMEMORY_LOCK  (lock),
      .iMEMORY_ORDER (order),
      .iMEMORY_RW    (rw),
      .iMEMORY_ADDR  (addr),
      .iMEMORY_DATA  (data),
      .iERR_RD       (rd),
      .oERR_EMPTY    (err_empty),
      .oERR_TYPE     (err_type),
      .oERR_INDEX    (err_index),
      .oERR_RESULT   (err_result),
      .oERR_EXPECT   (err_expect),
      .oERR_OVERFLOW (err_ovf),
      .oLOG_VALID    (log_valid),
      .oLOG_DATA     (log_data),
      .oCHECK_COUNT  (check_count),
      .oFAIL_COUNT   (fail_count),
      .oFINISH       (finish),
      .oPASS         (pass),
      .oTIMEOUT      (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct {
      logic [31:0] typ;
      logic [31:0] idx;
      logic [31:0] res;
      logic [31:0] exp;
   } rec_t;

   rec_t        mq[$];
   logic [31:0] m_check, m_fail, m_type, m_index, m_result, m_expect, m_log_data;
   bit          m_log_valid, m_done, m_tmo, m_ovf;
   int unsigned m_cycles;

   function automatic logic [31:0] sat1(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function void model_reset();
      mq.delete();
      m_check = 0; m_fail = 0; m_type = 0; m_index = 0; m_result = 0; m_expect = 0;
      m_log_data = 0; m_log_valid = 0; m_done = 0; m_tmo = 0; m_ovf = 0; m_cycles = 0;
   endfunction

   function void model_step();
      logic [31:0] dv;
      bit          running, acc, fin;
      rec_t        r;
      dv      = {<<8{data}};
      running = !m_done && !m_tmo;
      acc     = req && !lock && (order == 2'h2) && rw && ((addr >> 5) == (BASE >> 5)) &&
                (addr % 4 == 0) && running;
      fin     = 0;
      m_log_valid = 0;
      if (rd && mq.size() > 0) r = mq.pop_front();
      if (acc) begin
         case (addr - BASE)
            32'h00: begin
               m_check = sat1(m_check);
               if (dv[0] == 1'b0) begin
                  m_fail = sat1(m_fail);
                  r = '{m_type, m_index, m_result, m_expect};
                  if (mq.size() < DEPTH) mq.push_back(r);
                  else m_ovf = 1;
               end
            end
            32'h04: fin = 1;
            32'h08: begin m_log_valid = 1; m_log_data = dv; end
            32'h0C: m_type   = dv;
            32'h10: m_index  = dv;
            32'h14: m_result = dv;
            32'h18: m_expect = dv;
            default: ;
         endcase
      end
      if (fin) m_done = 1;
      else if (running && TMO != 0 && m_cycles == TMO - 1) m_tmo = 1;
      if (running) m_cycles++;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   always @(posedge clk) begin
      #1;
      if (cmp_en) begin
         rec_t h;
         h = (mq.size() > 0) ? mq[0] : '{32'd0, 32'd0, 32'd0, 32'd0};
         chk("m_empty",   {31'd0, err_empty},   {31'd0, mq.size() == 0});
         chk("m_type",    err_type,             h.typ);
         chk("m_index",   err_index,            h.idx);
         chk("m_result",  err_result,           h.res);
         chk("m_expect",  err_expect,           h.exp);
         chk("m_ovf",     {31'd0, err_ovf},     {31'd0, m_ovf});
         chk("m_logv",    {31'd0, log_valid},   {31'd0, m_log_valid});
         chk("m_logd",    log_data,             m_log_data);
         chk("m_check",   check_count,          m_check);
         chk("m_fail",    fail_count,           m_fail);
         chk("m_finish",  {31'd0, finish},      {31'd0, m_done || m_tmo});
         chk("m_timeout", {31'd0, timeout},     {31'd0, m_tmo});
         chk("m_pass",    {31'd0, pass},        {31'd0, m_done && m_fail == 0 && m_check != 0});
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [31:0] sw(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic lk = 1'b0,
                      input logic [1:0] ord = 2'h2, input logic wr = 1'b1, input logic pop = 1'b0);
      @(negedge clk);
      req = 1'b1; lock = lk; order = ord; rw = wr; addr = a; data = d; rd = pop;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         req = 1'b0; lock = 1'b0; rw = 1'b0; rd = 1'b0;
      end
   endtask

   task automatic pop1();
      @(negedge clk);
      req = 1'b0; rd = 1'b1;
      idle(1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req = 0; lock = 0; order = 0; rw = 0; addr = 0; data = 0; rd = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      req = 0; lock = 0; order = 0; rw = 0; addr = 0; data = 0; rd = 0;
      do_reset();
      cmp_en = 1'b1;

      // reset state
      chk("rst_empty", {31'd0, err_empty}, 32'd1);
      chk("rst_check", check_count, 32'd0);
      chk("rst_finish", {31'd0, finish}, 32'd0);

      // three passing checks then finish
      repeat (3) bus(BASE, 32'h0100_0000);
      bus(BASE + 32'h4, 32'h0);
      idle(1);
      chk("pass_check", check_count, 32'd3);
      chk("pass_fail", fail_count, 32'd0);
      chk("pass_finish", {31'd0, finish}, 32'd1);
      chk("pass_pass", {31'd0, pass}, 32'd1);
      chk("pass_empty", {31'd0, err_empty}, 32'd1);

      // one failing check with staged record
      do_reset();
      bus(BASE + 32'h0C, sw(32'd5));
      bus(BASE + 32'h10, sw(32'd7));
      bus(BASE + 32'h14, sw(32'h12));
      bus(BASE + 32'h18, sw(32'h34));
      bus(BASE, 32'h0);
      bus(BASE + 32'h4, 32'h0);
      idle(1);
      chk("fail_count", fail_count, 32'd1);
      chk("fail_pass", {31'd0, pass}, 32'd0);
      chk("fail_type", err_type, 32'd5);
      chk("fail_index", err_index, 32'd7);
      chk("fail_result", err_result, 32'h12);
      chk("fail_expect", err_expect, 32'h34);
      pop1();
      chk("fail_popped", {31'd0, err_empty}, 32'd1);

      // overflow: three failures into a two-deep queue
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         bus(BASE + 32'h0C, sw(i));
         bus(BASE, 32'h0);
      end
      idle(1);
      chk("ovf_flag", {31'd0, err_ovf}, 32'd1);
      chk("ovf_head1", err_type, 32'd1);
      pop1();
      chk("ovf_head2", err_type, 32'd2);
      pop1();
      chk("ovf_empty", {31'd0, err_empty}, 32'd1);

      // full queue: simultaneous push and pop
      do_reset();
      for (int i = 1; i <= 2; i++) begin
         bus(BASE + 32'h0C, sw(i));
         bus(BASE, 32'h0);
      end
      bus(BASE + 32'h0C, sw(32'd3));
      bus(BASE, 32'h0, 1'b0, 2'h2, 1'b1, 1'b1);
      idle(1);
      chk("pp_ovf", {31'd0, err_ovf}, 32'd0);
      chk("pp_head", err_type, 32'd2);
      pop1();
      chk("pp_head2", err_type, 32'd3);
      pop1();
      chk("pp_empty", {31'd0, err_empty}, 32'd1);

      // log strobe
      bus(BASE + 32'h8, 32'h7856_3412);
      idle(1);
      chk("log_valid", {31'd0, log_valid}, 32'd1);
      chk("log_data", log_data, 32'h1234_5678);
      idle(1);
      chk("log_single", {31'd0, log_valid}, 32'd0);

      // ignored accesses
      do_reset();
      bus(BASE, 32'h0, 1'b1);
      bus(BASE, 32'h0, 1'b0, 2'h0);
      bus(BASE + 32'h20, 32'h0);
      bus(BASE, 32'h0, 1'b0, 2'h2, 1'b0);
      bus(BASE + 32'h2, 32'h0);
      idle(1);
      chk("ign_check", check_count, 32'd0);
      chk("ign_empty", {31'd0, err_empty}, 32'd1);

      // watchdog
      do_reset();
      n = 0;
      for (int c = 0; c < 4 * TMO; c++) begin
         @(posedge clk);
         #1;
         n++;
         if (timeout) break;
      end
      chk("tmo_latency", n, TMO);
      chk("tmo_finish", {31'd0, finish}, 32'd1);
      chk("tmo_pass", {31'd0, pass}, 32'd0);
      bus(BASE, 32'h0);
      idle(1);
      chk("tmo_frozen", check_count, 32'd0);

      // asynchronous reset mid-run
      do_reset();
      bus(BASE, 32'h0);
      bus(BASE, 32'h0);
      bus(BASE + 32'h8, 32'hFFFF_FFFF);
      idle(1);
      chk("mid_pre", check_count, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_check", check_count, 32'd0);
      chk("mid_fail", fail_count, 32'd0);
      chk("mid_empty", {31'd0, err_empty}, 32'd1);
      chk("mid_type", err_type, 32'd0);
      chk("mid_log", {31'd0, log_valid}, 32'd0);
      chk("mid_logd", log_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // randomized episodes
      for (int ep = 0; ep < 30; ep++) begin
         int len;
         do_reset();
         len = $urandom_range(40, 160);
         for (int c = 0; c < len; c++) begin
            int k;
            logic [31:0] off;
            @(negedge clk);
            k = $urandom_range(0, 99);
            if (k < 40)      off = 32'h00;
            else if (k < 42) off = 32'h04;
            else if (k < 52) off = 32'h08;
            else if (k < 92) off = 32'h0C + 4 * $urandom_range(0, 3);
            else             off = 32'h1C;
            addr = BASE + off;
            case ($urandom_range(0, 19))
               0: addr = addr + $urandom_range(1, 3);
               1: addr = addr + 32'h20;
               2: addr = BASE - 32'h4;
               default: ;
            endcase
            req   = ($urandom_range(0, 9) < 6);
            lock  = ($urandom_range(0, 9) == 0);
            order = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'h2;
            rw    = ($urandom_range(0, 9) != 0);
            data  = $urandom;
            rd    = ($urandom_range(0, 3) == 0);
         end
         idle(2);
      end

      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
